rab_slice_cfg_writer: RTL

//  Hardware sequencer that programs one RAB slice per descriptor over the pulp rab_conf AXI-Lite port.

---
 rtl/rab_slice_cfg_writer_pkg.sv | 120 ++++++++++++
 rtl/rab_slice_cfg_writer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rab_slice_cfg_writer_pkg.sv
// Shared types, constants and the slice word mux for the RAB slice config writer.
// Descriptor fields are held at their widest size; narrower configurations zero-extend into them.
package rab_slice_cfg_writer_pkg;

    localparam int unsigned RAB_DESC_AW = 64;
    localparam int unsigned RAB_LITE_AW = 32;
    localparam int unsigned RAB_LITE_DW = 32;

    localparam logic [RAB_LITE_AW-1:0] RAB_CFG_BASE = 32'hA800_0000;

    localparam logic [RAB_LITE_AW-1:0] RAB_SLICE_FIRST_LO_OFF = 32'h00;
    localparam logic [RAB_LITE_AW-1:0] RAB_SLICE_FIRST_HI_OFF = 32'h04;
    localparam logic [RAB_LITE_AW-1:0] RAB_SLICE_LAST_LO_OFF  = 32'h08;
    localparam logic [RAB_LITE_AW-1:0] RAB_SLICE_LAST_HI_OFF  = 32'h0C;
    localparam logic [RAB_LITE_AW-1:0] RAB_SLICE_BASE_LO_OFF  = 32'h10;
    localparam logic [RAB_LITE_AW-1:0] RAB_SLICE_BASE_HI_OFF  = 32'h14;
    localparam logic [RAB_LITE_AW-1:0] RAB_SLICE_FLAGS_OFF    = 32'h18;

    localparam int unsigned RAB_FLAG_RD_BIT = 0;
    localparam int unsigned RAB_FLAG_WR_BIT = 1;
    localparam int unsigned RAB_FLAG_EN_BIT = 2;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR_DATA,
        ST_RESP
    } rab_cfg_state_e;

    typedef struct packed {
        logic [RAB_LITE_AW-1:0] slice_off;
        logic [RAB_DESC_AW-1:0] first;
        logic [RAB_DESC_AW-1:0] last;
        logic [RAB_DESC_AW-1:0] base;
        logic [2:0]             flags;
    } rab_desc_t;

    typedef struct packed {
        logic [RAB_LITE_AW-1:0] off;
        logic [RAB_LITE_DW-1:0] data;
    } rab_word_t;

    typedef struct packed {
        logic [RAB_LITE_AW-1:0] addr;
        logic [2:0]             prot;
    } rab_lite_ax_t;

    typedef struct packed {
        logic [RAB_LITE_DW-1:0]   data;
        logic [RAB_LITE_DW/8-1:0] strb;
    } rab_lite_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } rab_lite_b_t;

    typedef struct packed {
        logic [RAB_LITE_DW-1:0] data;
        logic [1:0]             resp;
    } rab_lite_r_t;

    typedef struct packed {
        rab_lite_ax_t aw;
        logic         aw_valid;
        rab_lite_w_t  w;
        logic         w_valid;
        logic         b_ready;
        rab_lite_ax_t ar;
        logic         ar_valid;
        logic         r_ready;
    } rab_lite_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        rab_lite_b_t b;
        logic        b_valid;
        logic        ar_ready;
        rab_lite_r_t r;
        logic        r_valid;
    } rab_lite_resp_t;

    // idx is the position in the full 7-entry slice register list.
    function automatic rab_word_t rab_slice_word(input logic [2:0] idx, input rab_desc_t desc);
        rab_word_t word;
        word.off  = RAB_SLICE_FLAGS_OFF;
        word.data = RAB_LITE_DW'(desc.flags);
        case (idx)
            3'd0: begin
                word.off  = RAB_SLICE_FIRST_LO_OFF;
                word.data = desc.first[RAB_LITE_DW-1:0];
            end
            3'd1: begin
                word.off  = RAB_SLICE_FIRST_HI_OFF;
                word.data = desc.first[RAB_DESC_AW-1:RAB_LITE_DW];
            end
            3'd2: begin
                word.off  = RAB_SLICE_LAST_LO_OFF;
                word.data = desc.last[RAB_LITE_DW-1:0];
            end
            3'd3: begin
                word.off  = RAB_SLICE_LAST_HI_OFF;
                word.data = desc.last[RAB_DESC_AW-1:RAB_LITE_DW];
            end
            3'd4: begin
                word.off  = RAB_SLICE_BASE_LO_OFF;
                word.data = desc.base[RAB_LITE_DW-1:0];
            end
            3'd5: begin
                word.off  = RAB_SLICE_BASE_HI_OFF;
                word.data = desc.base[RAB_DESC_AW-1:RAB_LITE_DW];
            end
            default: ;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/rab_slice_cfg_writer.sv
// Expands one RAB slice descriptor into a sequence of AXI-Lite writes on the rab_conf port.
// One write is in flight at a time; a non-OKAY B response aborts the rest of the descriptor.
module rab_slice_cfg_writer
    import rab_slice_cfg_writer_pkg::*;
#(
    parameter int unsigned             AXI_AW       = 64,
    parameter int unsigned             AXI_LITE_AW  = 32,
    parameter int unsigned             AXI_LITE_DW  = 32,
    parameter logic [AXI_LITE_AW-1:0]  RAB_CFG_BASE = rab_slice_cfg_writer_pkg::RAB_CFG_BASE,
    parameter type                     axi_lite_req_t  = rab_lite_req_t,
    parameter type                     axi_lite_resp_t = rab_lite_resp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   desc_valid_i,
    output logic                   desc_ready_o,
    input  logic [AXI_LITE_AW-1:0] desc_slice_off_i,
    input  logic [AXI_AW-1:0]      desc_first_i,
    input  logic [AXI_AW-1:0]      desc_last_i,
    input  logic [AXI_AW-1:0]      desc_base_i,
    input  logic [2:0]             desc_flags_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [1:0]             err_resp_o,
    output axi_lite_req_t          cfg_req_o,
    input  axi_lite_resp_t         cfg_resp_i
);

    // Hi words are only written when the address does not fit in one data word.
    localparam bit         HasHi   = AXI_AW > AXI_LITE_DW;
    localparam logic [2:0] LastIdx = HasHi ? 3'd6 : 3'd3;

    rab_cfg_state_e         state_q, state_d;
    rab_desc_t              desc_q, desc_d;
    logic [2:0]             idx_q, idx_d;
    logic                   aw_valid_q, aw_valid_d;
    logic                   w_valid_q, w_valid_d;
    logic                   b_ready_q, b_ready_d;
    logic [AXI_LITE_AW-1:0] addr_q, addr_d;
    logic [AXI_LITE_DW-1:0] data_q, data_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [1:0]             err_resp_q, err_resp_d;

    logic       load;
    logic [2:0] load_idx;
    rab_desc_t  load_desc;
    rab_word_t  load_word;

    function automatic rab_word_t word_at(input logic [2:0] idx, input rab_desc_t desc);
        logic [2:0] pos;
        pos = HasHi ? idx : {idx[1:0], 1'b0};
        return rab_slice_word(pos, desc);
    endfunction

    always_comb begin
        state_d    = state_q;
        desc_d     = desc_q;
        idx_d      = idx_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        b_ready_d  = b_ready_q;
        addr_d     = addr_q;
        data_d     = data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_resp_d = err_resp_q;
        load       = 1'b0;
        load_idx   = idx_q;
        load_desc  = desc_q;

        case (state_q)
            ST_IDLE: begin
                if (desc_valid_i) begin
                    desc_d.slice_off = RAB_LITE_AW'(desc_slice_off_i);
                    desc_d.first     = RAB_DESC_AW'(desc_first_i);
                    desc_d.last      = RAB_DESC_AW'(desc_last_i);
                    desc_d.base      = RAB_DESC_AW'(desc_base_i);
                    desc_d.flags     = desc_flags_i;
                    idx_d            = 3'd0;
                    err_resp_d       = 2'b00;
                    load             = 1'b1;
                    load_idx         = 3'd0;
                    load_desc        = desc_d;
                    state_d          = ST_ADDR_DATA;
                end
            end
            ST_ADDR_DATA: begin
                if (aw_valid_q && cfg_resp_i.aw_ready) begin
                    aw_valid_d = 1'b0;
                end
                if (w_valid_q && cfg_resp_i.w_ready) begin
                    w_valid_d = 1'b0;
                end
                if (!aw_valid_d && !w_valid_d) begin
                    b_ready_d = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (cfg_resp_i.b_valid) begin
                    b_ready_d = 1'b0;
                    if (cfg_resp_i.b.resp != AXI_RESP_OKAY) begin
                        done_d     = 1'b1;
                        err_d      = 1'b1;
                        err_resp_d = cfg_resp_i.b.resp;
                        state_d    = ST_IDLE;
                    end else if (idx_q == LastIdx) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        load     = 1'b1;
                        load_idx = idx_d;
                        state_d  = ST_ADDR_DATA;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Payload is captured once per word so it stays stable while either valid is up.
        load_word = word_at(load_idx, load_desc);
        if (load) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            addr_d     = RAB_CFG_BASE + AXI_LITE_AW'(load_desc.slice_off)
                       + AXI_LITE_AW'(load_word.off);
            data_d     = AXI_LITE_DW'(load_word.data);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            desc_q     <= '0;
            idx_q      <= 3'd0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_resp_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            desc_q     <= desc_d;
            idx_q      <= idx_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            b_ready_q  <= b_ready_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_resp_q <= err_resp_d;
        end
    end

    always_comb begin
        cfg_req_o          = '0;
        cfg_req_o.aw.addr  = addr_q;
        cfg_req_o.aw_valid = aw_valid_q;
        cfg_req_o.w.data   = data_q;
        cfg_req_o.w.strb   = w_valid_q ? '1 : '0;
        cfg_req_o.w_valid  = w_valid_q;
        cfg_req_o.b_ready  = b_ready_q;
    end

    assign desc_ready_o = (state_q == ST_IDLE);
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign err_resp_o   = err_resp_q;

    // Read channel is never used.
    logic unused_read_resp;
    assign unused_read_resp = ^{cfg_resp_i.ar_ready, cfg_resp_i.r_valid, cfg_resp_i.r};

endmodule
